// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one fixed-latency CORDIC engine among four requesters.
// Optional quadrant folding into [-pi/2, pi/2] is enabled by defining CORDIC_SCHED_RANGE_REDUCE_EN.
module cordic_sched #(
    parameter int ENGINE_LATENCY = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [95:0] req_angle,
    output logic [3:0]  gnt,
    output logic        eng_valid,
    output logic [23:0] eng_angle,
    output logic [1:0]  eng_sign,
    input  logic [23:0] eng_sine,
    input  logic [23:0] eng_cosine,
    output logic        res_valid,
    output logic [1:0]  res_id,
    output logic        res_err,
    output logic [23:0] res_sine,
    output logic [23:0] res_cosine,
    output logic        busy
);

    localparam int DATA_W = 24;
    localparam int CNT_W  = $clog2(ENGINE_LATENCY + 2);
    localparam logic signed [DATA_W-1:0] PI      = 24'sh6487EE;
    localparam logic signed [DATA_W-1:0] HALF_PI = 24'sh3243F7;

    typedef enum logic [1:0] {FLUSH, IDLE, WAIT, RESP} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_ptr;
    logic               r_err;

    logic signed [DATA_W-1:0] w_ang [4];
    logic                     w_any;
    logic [1:0]               w_sel;
    logic [DATA_W+2:0]        w_red;

    // Returns {out_of_range, sign[1:0], angle}; sign bits are {negate sine, negate cosine}.
    function automatic logic [DATA_W+2:0] reduce(input logic signed [DATA_W-1:0] a);
        logic signed [DATA_W-1:0] ang;
        logic [1:0]               sgn;
        logic                     err;
        ang = a;
        sgn = 2'b00;
        err = 1'b0;
`ifdef CORDIC_SCHED_RANGE_REDUCE_EN
        if (a > PI || a < -PI) begin
            err = 1'b1;
        end else if (a > HALF_PI) begin
            ang = PI - a;
            sgn = 2'b01;
        end else if (a < -HALF_PI) begin
            ang = -PI - a;
            sgn = 2'b01;
        end
`else
        if (a > HALF_PI || a < -HALF_PI) begin
            err = 1'b1;
        end
`endif
        return {err, sgn, ang};
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_ang
        assign w_ang[gi] = $signed(req_angle[gi*DATA_W +: DATA_W]);
    end

    // Descending scan so the requester closest after the last grant wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_any = 1'b1;
                w_sel = r_ptr + 2'(k);
            end
        end
    end

    assign w_red = reduce(w_ang[w_sel]);
    assign busy  = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FLUSH;
            r_cnt      <= '0;
            r_ptr      <= 2'd3;
            r_err      <= 1'b0;
            gnt        <= '0;
            eng_valid  <= 1'b0;
            eng_angle  <= '0;
            eng_sign   <= '0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_err    <= 1'b0;
            res_sine   <= '0;
            res_cosine <= '0;
        end else begin
            gnt       <= '0;
            eng_valid <= 1'b0;
            res_valid <= 1'b0;
            case (r_state)
                FLUSH: begin
                    if (r_cnt == CNT_W'(ENGINE_LATENCY)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_any) begin
                        gnt       <= 4'b0001 << w_sel;
                        eng_valid <= ~w_red[DATA_W+2];
                        eng_sign  <= w_red[DATA_W+1:DATA_W];
                        eng_angle <= w_red[DATA_W-1:0];
                        res_id    <= w_sel;
                        r_ptr     <= w_sel;
                        r_err     <= w_red[DATA_W+2];
                        r_cnt     <= '0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_err) begin
                        res_valid  <= 1'b1;
                        res_err    <= 1'b1;
                        res_sine   <= '0;
                        res_cosine <= '0;
                        r_state    <= RESP;
                    end else if (r_cnt == CNT_W'(ENGINE_LATENCY)) begin
                        res_valid  <= 1'b1;
                        res_err    <= 1'b0;
                        res_sine   <= eng_sine;
                        res_cosine <= eng_cosine;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= FLUSH;
            endcase
        end
    end

endmodule

// File: doc/cordic_sched.md
CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 Parameter ENGINE_LATENCY, default 25: cycles from the engine sampling eng_valid until eng_sine/eng_cosine are stable.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester request; held high until gnt.
REQ-005 req_angle  input  96  requester i angle at bits [24i+23:24i]; signed Q3.21 radians.
REQ-006 gnt  output  4  one-hot, one-cycle grant; requester may drop req after it.
REQ-007 eng_valid / eng_angle / eng_sign  output  1/24/2  engine start pulse, reduced angle, negate bits ({sine,cosine}).
REQ-008 eng_sine, eng_cosine  input  24/24  engine results, signed Q3.21.
REQ-009 res_valid / res_id / res_err  output  1/2/1  one-cycle result strobe, requester index, out-of-range flag.
REQ-010 res_sine, res_cosine  output  24/24  results, held until next res_valid.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 States: FLUSH, IDLE, WAIT, RESP; one operation in flight at most.
REQ-013 IDLE with req!=0: round-robin grant starting at (last granted + 1) mod 4; on that edge load gnt, eng_valid=1, eng_angle, eng_sign, res_id; go to WAIT (cycle G).
REQ-014 gnt and eng_valid high only in cycle G; eng_angle/eng_sign held until next grant.
REQ-015 WAIT spans cycles G+1..G+ENGINE_LATENCY; at the end of G+ENGINE_LATENCY latch eng_sine/eng_cosine into res_sine/res_cosine; RESP in cycle G+ENGINE_LATENCY+1 with res_valid=1, res_err=0.
REQ-016 RESP -> IDLE; back-to-back grants are spaced exactly ENGINE_LATENCY+3 cycles.
REQ-017 Range reduction (macro on): |a|<=0x3243F7 (pi/2) -> eng_angle=a, eng_sign=00; a>0x3243F7 -> eng_angle=0x6487EE-a, eng_sign=01; a<-0x3243F7 -> eng_angle=-0x6487EE-a, eng_sign=01; 24-bit two's-complement arithmetic.
REQ-018 |a|>0x6487EE (pi) is out of range: gnt in cycle G, eng_valid stays 0, RESP in G+1 with res_err=1, res_sine=res_cosine=0.
REQ-019 Boundaries: a=+/-0x3243F7 passes unreduced; a=+/-0x6487EE reduces to 0 with eng_sign=01.
REQ-020 A req dropped before its gnt is not served; the pointer does not advance.
REQ-021 req from the requester whose result is pending is arbitrated normally once IDLE is reached.
REQ-022 FLUSH counts ENGINE_LATENCY+1 cycles, then enters IDLE; no grant is issued in FLUSH.

Reset
REQ-023 rst low: state FLUSH, flush counter 0, round-robin pointer 3 (requester 0 first), busy=1, all other outputs 0, effective immediately and asynchronously.
REQ-024 Reset during WAIT discards the in-flight operation; no res_valid is ever produced for it.

Configuration
REQ-025 Macro CORDIC_SCHED_RANGE_REDUCE_EN defined: REQ-017..REQ-019 apply.
REQ-026 Macro CORDIC_SCHED_RANGE_REDUCE_EN undefined: eng_angle=a, eng_sign=00 always; |a|>0x3243F7 is out of range per REQ-018.

Verification
REQ-027 Release rst with req=0001, angle 0 -> no gnt for ENGINE_LATENCY+1 cycles, then gnt=0001, eng_angle=0, eng_sign=00; res_valid exactly 26 cycles after gnt.
REQ-028 Macro on, req=0100, angle 0x6487EE -> eng_angle=0, eng_sign=01, res_id=2; res_cosine within 16 LSB of 0xE00000 and res_sine within 16 LSB of 0.
REQ-029 req=1111 held continuously -> gnt sequence 0001,0010,0100,1000,0001 with 28-cycle spacing.
REQ-030 req=0010, angle 0x700000 -> gnt then res_valid next cycle, res_err=1, res_id=1, outputs 0, eng_valid never high.
REQ-031 rst low 10 cycles into WAIT -> all outputs 0 at once, busy=1; after release no res_valid and a FLUSH of 26 cycles before the next gnt.
REQ-032 Macro off: angle 0x400000 -> res_err=1; angle 0x3243F7 -> eng_angle=0x3243F7, eng_sign=00.
